// File: rtl/cbfp_norm_pipe_pkg.sv
// cbfp_norm_pipe_pkg: shared sizing and arithmetic helpers for the block-floating-point normaliser.
package cbfp_norm_pipe_pkg;
  function automatic int exp_w(input int w);
    return $clog2(w);
  endfunction
  // Shift a sample so that block exponent e lands on the output scale t; rnd selects round-half-up.
  function automatic longint norm(input longint v, input int e, input int t, input bit rnd);
    longint sh;
    sh = longint'(t - e);
    if (e >= t) return v <<< (e - t);
    return rnd ? (v + (64'sd1 <<< (sh - 1))) >>> sh : v >>> sh;
  endfunction
  function automatic longint clamp(input longint v, input int w);
    longint hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 1;
    lo = -(64'sd1 <<< (w - 1));
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
  function automatic bit ovf(input longint v, input int w);
    return clamp(v, w) != v;
  endfunction
endpackage

// File: rtl/cbfp_norm_pipe_if.sv
// cbfp_norm_pipe_if: input and output beat streams of the normaliser with their valid/ready handshakes.
interface cbfp_norm_pipe_if import cbfp_norm_pipe_pkg::*; #(
  parameter int IN_W = 25,
  parameter int OUT_W = 12,
  parameter int NCHAN = 16,
  parameter int BLOCK_SIZE = 8
);
  localparam int NBLOCKS = NCHAN / BLOCK_SIZE;
  localparam int EXP_W = exp_w(IN_W);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [NCHAN-1:0][IN_W-1:0] data_re_in, data_im_in;
  logic [NCHAN-1:0][OUT_W-1:0] data_re_out, data_im_out;
  logic [NBLOCKS-1:0][EXP_W-1:0] blk_exp;
  logic [NBLOCKS-1:0] sat_flag;
  modport master (output in_valid, data_re_in, data_im_in, out_ready,
                  input in_ready, out_valid, data_re_out, data_im_out, blk_exp, sat_flag);
  modport slave (input in_valid, data_re_in, data_im_in, out_ready,
                 output in_ready, out_valid, data_re_out, data_im_out, blk_exp, sat_flag);
endinterface

// File: rtl/cbfp_norm_pipe_lsc.sv
// cbfp_lsc: combinational count of redundant sign bits; 0 and -1 report WIDTH-1.
module cbfp_lsc #(
  parameter int WIDTH = 25
)(
  input  logic [WIDTH-1:0] x,
  output logic [$clog2(WIDTH)-1:0] lsc
);
  localparam int W = $clog2(WIDTH);
  // Ascending scan: the highest bit differing from the sign is the last to write.
  always_comb begin
    lsc = W'(WIDTH - 1);
    for (int i = 0; i < WIDTH - 1; i++)
      if (x[i] != x[WIDTH-1]) lsc = W'(WIDTH - 2 - i);
  end
endmodule

// File: rtl/cbfp_norm_pipe.sv
// cbfp_norm_pipe: 3-stage elastic block-floating-point normaliser (sign count, block min, shift/round/saturate).
module cbfp_norm_pipe import cbfp_norm_pipe_pkg::*; #(
  parameter int IN_W = 25,
  parameter int OUT_W = 12,
  parameter int NCHAN = 16,
  parameter int BLOCK_SIZE = 8,
  parameter int TRUNC_VALUE = 13,
  parameter bit ROUND_EN = 1'b1,
  parameter bit SAT_EN = 1'b1
)(
  input logic clk,
  input logic rstn,
  cbfp_norm_pipe_if.slave bus
);
  localparam int NBLOCKS = NCHAN / BLOCK_SIZE;
  localparam int EXP_W = exp_w(IN_W);
  typedef struct packed {
    logic [IN_W-1:0] re;
    logic [IN_W-1:0] im;
    logic [EXP_W-1:0] e;
  } samp_t;
  // s1 carries each sample's own exponent, s2 carries its block's exponent.
  samp_t [NCHAN-1:0] s1, s2;
  logic v1, v2, v3, ld1, ld2, ld3;
  logic [EXP_W-1:0] lre [NCHAN];
  logic [EXP_W-1:0] lim [NCHAN];
  logic [EXP_W-1:0] bmin [NBLOCKS];
  logic [NCHAN-1:0][OUT_W-1:0] nre, nim, re3, im3;
  logic [NCHAN-1:0] cl;
  logic [NBLOCKS-1:0] sat_n, sat3;
  logic [NBLOCKS-1:0][EXP_W-1:0] exp3;
  assign ld3 = !v3 || bus.out_ready;
  assign ld2 = !v2 || ld3;
  assign ld1 = !v1 || ld2;
  assign bus.in_ready = ld1;
  assign bus.out_valid = v3;
  assign bus.data_re_out = re3;
  assign bus.data_im_out = im3;
  assign bus.blk_exp = exp3;
  assign bus.sat_flag = sat3;
  for (genvar i = 0; i < NCHAN; i++) begin : g_s
    logic signed [63:0] r_re, r_im;
    cbfp_lsc #(.WIDTH(IN_W)) u_re (.x(bus.data_re_in[i]), .lsc(lre[i]));
    cbfp_lsc #(.WIDTH(IN_W)) u_im (.x(bus.data_im_in[i]), .lsc(lim[i]));
    always_comb begin
      r_re = norm(longint'($signed(s2[i].re)), int'(s2[i].e), TRUNC_VALUE, ROUND_EN);
      r_im = norm(longint'($signed(s2[i].im)), int'(s2[i].e), TRUNC_VALUE, ROUND_EN);
      nre[i] = OUT_W'(SAT_EN ? clamp(r_re, OUT_W) : r_re);
      nim[i] = OUT_W'(SAT_EN ? clamp(r_im, OUT_W) : r_im);
      cl[i] = SAT_EN && (ovf(r_re, OUT_W) || ovf(r_im, OUT_W));
    end
  end
  always_comb begin
    for (int b = 0; b < NBLOCKS; b++) begin
      bmin[b] = EXP_W'(IN_W - 1);
      for (int j = 0; j < BLOCK_SIZE; j++)
        bmin[b] = s1[b*BLOCK_SIZE+j].e < bmin[b] ? s1[b*BLOCK_SIZE+j].e : bmin[b];
      sat_n[b] = |cl[b*BLOCK_SIZE +: BLOCK_SIZE];
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      s1 <= '0;
      s2 <= '0;
      re3 <= '0;
      im3 <= '0;
      exp3 <= '0;
      sat3 <= '0;
    end else begin
      if (ld1) begin
        v1 <= bus.in_valid;
        if (bus.in_valid)
          for (int i = 0; i < NCHAN; i++)
            s1[i] <= '{re: bus.data_re_in[i], im: bus.data_im_in[i],
                       e: lre[i] < lim[i] ? lre[i] : lim[i]};
      end
      if (ld2) begin
        v2 <= v1;
        if (v1)
          for (int i = 0; i < NCHAN; i++)
            s2[i] <= '{re: s1[i].re, im: s1[i].im, e: bmin[i/BLOCK_SIZE]};
      end
      if (ld3) begin
        v3 <= v2;
        if (v2) begin
          re3 <= nre;
          im3 <= nim;
          sat3 <= sat_n;
          for (int b = 0; b < NBLOCKS; b++) exp3[b] <= s2[b*BLOCK_SIZE].e;
        end
      end
    end
  end
endmodule
